// File: rtl/i2s_tx_cs4344.sv
// i2s_tx_cs4344 - I2S transmitter for the CS4344 stereo DAC.
//
// Takes stereo 16-bit PCM pairs from the upstream PCM FIFO over a valid/ready
// handshake and shifts them out as standard I2S with MCLK = 256*fs and
// SCLK = 64*fs. A fractional NCO turns the system clock into a 512*fs tick;
// a 9-bit frame counter advanced by that tick produces every DAC pin.
// All state changes on the falling edge of clk.
//
// Ports:
//   clk           system clock (logic runs on negedge)
//   rst           synchronous active-high reset
//   s_valid       upstream has a sample pair
//   s_ready       pair is accepted this cycle (hold register empty)
//   s_left        signed left sample
//   s_right       signed right sample
//   mute          forces sdin low from the next slot boundary
//   mclk          DAC master clock (256*fs)
//   sclk          DAC bit clock (64*fs)
//   lrck          word select, 0 = left channel
//   sdin          DAC serial data, MSB first, one bit after the lrck edge
//   frame_start   one-cycle pulse as a new frame begins
//   underrun      one-cycle pulse when a frame starts with no pair held
//   underrun_cnt  saturating count of underruns
module i2s_tx_cs4344 #(
    parameter int unsigned CLK_DIV = 2214425,
    parameter int unsigned CLK_INC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_left,
    input  logic [15:0] s_right,
    input  logic        mute,
    output logic        mclk,
    output logic        sclk,
    output logic        lrck,
    output logic        sdin,
    output logic        frame_start,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);

    // Phase step subtracted on a tick; tick fires when acc + CLK_INC would
    // reach CLK_DIV, so the tick rate is f_clk * CLK_INC / CLK_DIV.
    localparam logic [21:0] STEP = 22'(CLK_DIV - CLK_INC);
    localparam logic [21:0] INC  = 22'(CLK_INC);

    logic [21:0] acc_q;
    logic [21:0] acc_d;
    logic [8:0]  ctr_q;
    logic [8:0]  ctr_d;

    logic        tick;
    logic        frame_tick;
    logic        slot_tick;
    logic        load;
    logic        underrun_d;

    logic        hold_full_q;
    logic [15:0] hold_l_q;
    logic [15:0] hold_r_q;
    logic [15:0] active_l_q;
    logic [15:0] active_r_q;

    logic        mclk_q;
    logic        sclk_q;
    logic        lrck_q;
    logic        sdin_q;
    logic        sdin_d;
    logic        frame_start_q;
    logic        underrun_q;
    logic [15:0] underrun_cnt_q;
    wire  [15:0] underrun_cnt_d;

    logic [4:0]  slot;
    logic [3:0]  bit_idx;
    logic [15:0] word;

    always_comb begin
        tick       = (acc_q >= STEP);
        acc_d      = tick ? (acc_q - STEP) : (acc_q + INC);
        ctr_d      = tick ? (ctr_q + 9'd1) : ctr_q;
        frame_tick = tick && (ctr_q == 9'd511);
        slot_tick  = tick && (ctr_d[2:0] == 3'd0);

        // Slot/channel come from the post-update counter. At a frame start
        // the slot is 0 (always silent), so using the not-yet-updated active
        // word there is harmless; the new pair is first read in left slot 1.
        slot    = ctr_d[7:3];
        word    = ctr_d[8] ? active_r_q : active_l_q;
        bit_idx = 4'(5'd16 - slot);

        sdin_d = sdin_q;
        if (slot_tick) begin
            sdin_d = !mute && (slot >= 5'd1) && (slot <= 5'd16) && word[bit_idx];
        end

        load       = s_valid && s_ready;
        underrun_d = frame_tick && !hold_full_q;
    end

    assign underrun_cnt_d = (underrun_d && (underrun_cnt_q != 16'hFFFF))
                          ? (underrun_cnt_q + 16'd1) : underrun_cnt_q;

    assign s_ready = !rst && !hold_full_q;

    always_ff @(negedge clk) begin
        if (rst) begin
            acc_q          <= '0;
            ctr_q          <= '0;
            hold_full_q    <= 1'b0;
            hold_l_q       <= '0;
            hold_r_q       <= '0;
            active_l_q     <= '0;
            active_r_q     <= '0;
            mclk_q         <= 1'b0;
            sclk_q         <= 1'b0;
            lrck_q         <= 1'b0;
            sdin_q         <= 1'b0;
            frame_start_q  <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            ctr_q <= ctr_d;

            if (tick) begin
                mclk_q <= ctr_d[0];
                sclk_q <= ctr_d[2];
                lrck_q <= ctr_d[8];
            end
            sdin_q <= sdin_d;

            frame_start_q  <= frame_tick;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;

            if (frame_tick) begin
                if (hold_full_q) begin
                    active_l_q  <= hold_l_q;
                    active_r_q  <= hold_r_q;
                    hold_full_q <= 1'b0;
                end else begin
                    active_l_q <= '0;
                    active_r_q <= '0;
                end
            end

            // load only happens with the hold empty, so it never collides
            // with the frame-start drain above.
            if (load) begin
                hold_l_q    <= s_left;
                hold_r_q    <= s_right;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign mclk         = mclk_q;
    assign sclk         = sclk_q;
    assign lrck         = lrck_q;
    assign sdin         = sdin_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_tx_cs4344.sv
module tb_i2s_tx_cs4344;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    // DUT 1: tick every cycle
    logic        rst, s_valid, mute;
    logic [15:0] s_left, s_right;
    logic        s_ready, mclk, sclk, lrck, sdin, frame_start, underrun;
    logic [15:0] underrun_cnt;

    // DUT 2: default NCO, 50 MHz clock, idle input
    logic        rst2;
    logic        s_ready2, mclk2, sclk2, lrck2, sdin2, fs2, ur2;
    logic [15:0] cnt2;

    i2s_tx_cs4344 #(.CLK_DIV(1), .CLK_INC(1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .mute(mute),
        .mclk(mclk), .sclk(sclk), .lrck(lrck), .sdin(sdin),
        .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    i2s_tx_cs4344 dut2 (
        .clk(clk), .rst(rst2), .s_valid(1'b0), .s_ready(s_ready2),
        .s_left(16'h0000), .s_right(16'h0000), .mute(1'b0),
        .mclk(mclk2), .sclk(sclk2), .lrck(lrck2), .sdin(sdin2),
        .frame_start(fs2), .underrun(ur2), .underrun_cnt(cnt2)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of DUT 1 ----------------
    int          m_ctr;
    bit          m_pend_full;
    logic [15:0] m_pend_l, m_pend_r, m_play_l, m_play_r, m_cnt;
    bit          e_mclk, e_sclk, e_lrck, e_sdin, e_fs, e_ur;
    bit          force_cnt = 0;

    always @(negedge clk) begin : model
        bit          accept;
        int          old, slot;
        logic [15:0] word;
        if (rst) begin
            m_ctr = 0; m_pend_full = 0; m_cnt = 16'h0;
            m_pend_l = 0; m_pend_r = 0; m_play_l = 0; m_play_r = 0;
            e_mclk = 0; e_sclk = 0; e_lrck = 0; e_sdin = 0; e_fs = 0; e_ur = 0;
        end else begin
            accept = s_valid && !m_pend_full;
            old    = m_ctr;
            m_ctr  = (m_ctr + 1) % 512;
            e_fs = 0; e_ur = 0;
            if (old == 511) begin
                e_fs = 1;
                if (m_pend_full) begin
                    m_play_l = m_pend_l; m_play_r = m_pend_r; m_pend_full = 0;
                end else begin
                    m_play_l = 0; m_play_r = 0; e_ur = 1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
            if (force_cnt) m_cnt = 16'hFFFF;
            if (accept) begin
                m_pend_l = s_left; m_pend_r = s_right; m_pend_full = 1;
            end
            e_mclk = (m_ctr % 2) == 1;
            e_sclk = ((m_ctr / 4) % 2) == 1;
            e_lrck = (m_ctr / 256) == 1;
            if (m_ctr % 8 == 0) begin
                slot = (m_ctr % 256) / 8;
                word = (m_ctr >= 256) ? m_play_r : m_play_l;
                e_sdin = (!mute && slot >= 1 && slot <= 16) ? word[16 - slot] : 1'b0;
            end
        end
    end

    // ---------------- model of DUT 2 (pure arithmetic) ----------------
    longint n2 = 0;
    function automatic longint ticks2(input longint n);
        return (n * 64'd1000000) / 64'd2214425;
    endfunction

    always @(negedge clk) begin
        if (rst2) n2 = 0;
        else n2 = n2 + 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        longint t, c;
        bit     fs_e;
        if (chk_en) begin
            chk("s_ready", s_ready, !rst && !m_pend_full);
            chk("mclk", mclk, e_mclk);
            chk("sclk", sclk, e_sclk);
            chk("lrck", lrck, e_lrck);
            chk("sdin", sdin, e_sdin);
            chk("frame_start", frame_start, e_fs);
            chk("underrun", underrun, e_ur);
            chk("underrun_cnt", underrun_cnt, m_cnt);

            t = ticks2(n2);
            c = t % 512;
            fs_e = (n2 > 0) && ((t / 512) != (ticks2(n2 - 1) / 512));
            chk("nco_mclk", mclk2, 16'(c % 2));
            chk("nco_sclk", sclk2, 16'((c / 4) % 2));
            chk("nco_lrck", lrck2, 16'(c / 256));
            chk("nco_fs", fs2, fs_e);
            chk("nco_ur", ur2, fs_e);
            chk("nco_cnt", cnt2, 16'(t / 512));
            chk("nco_ready", s_ready2, !rst2);
            chk("nco_sdin", sdin2, 1'b0);
        end
    end

    // ---------------- capture of serial words at sclk rising edges ----------------
    int          rise_cnt;
    bit          prev_s, prev_l;
    logic [15:0] shreg, last_l = 0, last_r = 0;

    always @(posedge clk) begin
        if (rst) begin
            rise_cnt = 0; prev_s = 0; prev_l = 0;
        end else begin
            if (lrck !== prev_l) rise_cnt = 0;
            if (sclk && !prev_s) begin
                if (rise_cnt >= 1 && rise_cnt <= 16) shreg = {shreg[14:0], sdin};
                if (rise_cnt == 16) begin
                    if (lrck) last_r = shreg;
                    else last_l = shreg;
                end
                rise_cnt++;
            end
            prev_s = sclk; prev_l = lrck;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_ctr(input int tgt);
        bit ok;
        ok = 0;
        for (int i = 0; i < 1100; i++) begin
            if (m_ctr == tgt) begin
                ok = 1;
                break;
            end
            cyc(1);
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL wait_ctr: counter never reached %0d", tgt);
        end
    endtask

    initial begin
        logic [15:0] dl, xl, xr;
        int          acc_n, ur_seen;
        bit          took;

        rst = 1; rst2 = 1; s_valid = 0; mute = 0; s_left = 0; s_right = 0;
        cyc(3);
        chk_en = 1;
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_cnt", underrun_cnt, 16'h0);
        rst = 0; rst2 = 0;

        // first frame: idle -> underrun
        cyc(512);
        chk("first_fs", frame_start, 1'b1);
        chk("first_ur", underrun, 1'b1);
        chk("first_cnt", underrun_cnt, 16'h0001);

        // known pair plays in frame 2
        s_valid = 1; s_left = 16'h8001; s_right = 16'h7FFE;
        cyc(1);
        s_valid = 0;
        chk("hold_busy", s_ready, 1'b0);
        wait_ctr(511);
        chk("ready_before_fs", s_ready, 1'b0);
        cyc(1);
        chk("ready_after_fs", s_ready, 1'b1);
        chk("fs2_no_ur", underrun, 1'b0);
        cyc(512);
        chk("word_left", last_l, 16'h8001);
        chk("word_right", last_r, 16'h7FFE);
        chk("cnt_after_f3", underrun_cnt, 16'h0002);

        // continuous valid with incrementing samples
        acc_n = 0;
        dl = 16'($urandom);
        s_valid = 1; s_left = dl; s_right = ~dl;
        for (int i = 0; i < 1536; i++) begin
            took = s_ready;
            cyc(1);
            if (took) begin
                acc_n++; dl = dl + 16'd1; s_left = dl; s_right = ~dl;
            end
        end
        s_valid = 0;
        chk("accepts_3_frames", 16'(acc_n), 16'd3);
        chk("no_new_underrun", underrun_cnt, 16'h0002);

        // valid rises in the frame-start cycle with the hold empty
        wait_ctr(511);
        xl = 16'($urandom); xr = 16'($urandom);
        s_valid = 1; s_left = xl; s_right = xr;
        cyc(1);
        s_valid = 0;
        chk("late_ur", underrun, 1'b1);
        chk("late_cnt", underrun_cnt, 16'h0003);
        cyc(1024);
        chk("late_left", last_l, xl);
        chk("late_right", last_r, xr);

        // random traffic with mute
        for (int i = 0; i < 2048; i++) begin
            s_valid = ($urandom_range(3) == 0);
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
            if ($urandom_range(63) == 0) mute = ~mute;
            cyc(1);
        end
        s_valid = 0; mute = 0;

        // saturation
        wait_ctr(100);
        force dut.underrun_cnt_d = 16'hFFFF;
        force_cnt = 1;
        cyc(1);
        release dut.underrun_cnt_d;
        force_cnt = 0;
        ur_seen = 0;
        for (int i = 0; i < 1200; i++) begin
            cyc(1);
            if (underrun) ur_seen++;
        end
        chk("sat_pulse", 16'(ur_seen >= 1), 16'd1);
        chk("sat_cnt", underrun_cnt, 16'hFFFF);

        // reset in the right channel with a pair held
        wait_ctr(200);
        s_valid = 1; s_left = 16'hFFFF; s_right = 16'hFFFF;
        cyc(1);
        s_valid = 0;
        wait_ctr(300);
        rst = 1;
        cyc(1);
        chk("mid_rst_ready", s_ready, 1'b0);
        chk("mid_rst_mclk", mclk, 1'b0);
        chk("mid_rst_sclk", sclk, 1'b0);
        chk("mid_rst_lrck", lrck, 1'b0);
        chk("mid_rst_sdin", sdin, 1'b0);
        chk("mid_rst_cnt", underrun_cnt, 16'h0);
        cyc(2);
        rst = 0;
        cyc(255);
        chk("restart_lrck_lo", lrck, 1'b0);
        cyc(1);
        chk("restart_lrck_hi", lrck, 1'b1);
        cyc(256);
        chk("restart_ur", underrun, 1'b1);
        chk("restart_cnt", underrun_cnt, 16'h0001);
        cyc(512);
        chk("discard_left", last_l, 16'h0000);
        chk("discard_right", last_r, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_tx_cs4344.md
Name: i2s_tx_cs4344

Overview:
- Downstream audio stage for the FMV mapper.
- Consumes stereo 16-bit PCM sample pairs from the PCM FIFO through a valid/ready handshake.
- Serialises them as standard I2S (MCLK = 256·fs, SCLK = 64·fs) to the CS4344 DAC pins.
- Detects and counts FIFO underruns; provides a mute input.

Parameters:
- CLK_DIV, 2214425, fractional divider denominator for the tick NCO.
- CLK_INC, 1000000, fractional divider increment. Tick rate = f_clk·CLK_INC/CLK_DIV = 512·fs (22.5792 MHz at 50 MHz clk, fs = 44.1 kHz).

Ports:
- clk  in  1  system clock; all logic on negedge clk.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  sample pair available.
- s_ready  out  1  block accepts the pair this cycle.
- s_left  in  16  signed left sample.
- s_right  in  16  signed right sample.
- mute  in  1  force sdin to 0; consumption continues.
- mclk  out  1  DAC master clock.
- sclk  out  1  DAC serial bit clock.
- lrck  out  1  word select, 0 = left.
- sdin  out  1  serial data.
- frame_start  out  1  one-cycle pulse when a new frame starts.
- underrun  out  1  one-cycle pulse, no sample available at frame start.
- underrun_cnt  out  16  saturating underrun count.

Behaviour:
- Reset: acc=0, ctr=0, hold_full=0, active_l=active_r=0.
  - All outputs 0; underrun_cnt=0; s_ready=0 while rst.
  - rst mid-frame aborts immediately; the held sample is discarded.
- NCO: 22-bit acc; tick = (acc >= CLK_DIV-CLK_INC).
  - On tick: acc <= acc-(CLK_DIV-CLK_INC); else acc <= acc+CLK_INC.
- ctr: 9-bit, advances by 1 on each tick and wraps 511 -> 0.
  - Outputs are registered and derived from the post-update ctr: mclk=ctr[0], sclk=ctr[2], lrck=ctr[8].
  - Slot s = ctr[7:3], 32 slots per channel.
  - sclk falls on slot entry and rises mid-slot; the DAC samples on the rising edge.
- Hold register: s_ready = !rst & !hold_full.
  - On s_valid & s_ready: hold_l/hold_r <= inputs, hold_full <= 1.
- Frame start: the tick where ctr wraps 511 -> 0. frame_start pulses that cycle.
  - If hold_full: active <= hold, hold_full <= 0.
  - Else: active <= 0, underrun pulses, underrun_cnt increments (saturates at 0xFFFF).
- Simultaneous cases:
  - Hold empty at frame start while s_valid=1: counts as underrun; the pair still loads into hold for the next frame.
  - Hold full at frame start: s_ready was 0, so no conflict.
- sdin data mapping (I2S, 1-bit delay after lrck edge):
  - Slot 0 = 0.
  - Slots 1..16 = bits 15..0 of the channel word (active_l when ctr[8]=0, active_r when ctr[8]=1).
  - Slots 17..31 = 0.
- sdin timing:
  - Registered; changes only on the tick entering a slot (ctr[2:0] becomes 0).
  - The new active pair is used from left slot 1 of the frame it was loaded in.
- mute: sdin forced 0 from the next slot boundary; handshake and underrun logic are unaffected.
- Ticks drive all serial outputs; no output changes in non-tick cycles, except the s_ready, frame_start and underrun pulses.

Test Plan:
- CLK_INC=1, CLK_DIV=1 (tick every cycle), reset then idle: mclk toggles every cycle, sclk period 8, lrck period 512; the first frame start gives underrun=1, underrun_cnt=1, sdin=0 throughout.
- Push pair L=0x8001, R=0x7FFE before the 2nd frame start:
  - sclk rising edges in left slots 1..16 sample 1,0,...,0,1.
  - Right slots 1..16 sample 0,1,...,1,0.
  - s_ready returns to 1 the cycle after the frame-start load.
- Hold s_valid=1 continuously with an incrementing sample: exactly one pair is accepted per 512 ticks; no underrun after the first frame.
- s_valid rises in the same cycle as frame start with hold empty: underrun pulses and the pair appears on sdin in the following frame.
- Force underrun_cnt to 0xFFFF, then starve: the count stays at 0xFFFF and the pulse still fires.
- Assert rst mid-right-channel: the next cycle has all outputs 0 and s_ready=0. After release, ctr restarts at 0 and a sample previously in hold is not played.
- Default parameters, 50 MHz clk, 10 ms run: lrck frequency 44100 Hz ±1 Hz.
